// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_capture
//  Description : Measures a PWM waveform (looped back from the scope pin or
//                from an external source). Reports high time and period in
//                units of enabled `tick` samples and publishes each complete
//                period with a one-cycle `valid` strobe.
//
//  Ports       : clk          - single clock, rising edge
//                reset        - synchronous, active-high, highest priority
//                tick         - sample enable for FSM and counter
//                pwm_in       - asynchronous PWM input under measurement
//                clr_ovf      - synchronous clear of the overflow flag
//                high_count   - high samples in the last complete period
//                period_count - samples from rise up to (excl.) next rise
//                valid        - one-clk strobe, counts updated same cycle
//                overflow     - sticky, a period/phase exceeded 2^CW-1
//
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture #(
    parameter int CW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          pwm_in,
    input  logic          clr_ovf,
    output logic [CW-1:0] high_count,
    output logic [CW-1:0] period_count,
    output logic          valid,
    output logic          overflow
);

    localparam logic [CW-1:0] c_cnt_max = '1;
    localparam logic [CW-1:0] c_cnt_one = CW'(1);

    typedef enum logic [1:0] {
        ST_ARM       = 2'd0,
        ST_WAIT_RISE = 2'd1,
        ST_HIGH      = 2'd2,
        ST_LOW       = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t        r_state;
    logic          r_sync_meta;
    logic          r_sync;
    logic          r_lvl;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_hi;
    logic [CW-1:0] r_high_count;
    logic [CW-1:0] r_period_count;
    logic          r_valid;
    logic          r_overflow;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    state_t        w_state;
    logic          w_lvl;
    logic [CW-1:0] w_cnt;
    logic [CW-1:0] w_hi;
    logic [CW-1:0] w_high_count;
    logic [CW-1:0] w_period_count;
    logic          w_valid;
    logic          w_ovf_set;
    logic          w_overflow;
    logic          w_rise;
    logic          w_fall;
    logic          w_at_max;

    // Two-flop synchronizer. It is intentionally left out of reset so that
    // it keeps tracking the line level while reset is held; on release the
    // ARM state then sees the true level and rejects a pulse already in
    // progress instead of mistaking it for a fresh rising edge.
    always_ff @(posedge clk) begin
        r_sync_meta <= pwm_in;
        r_sync      <= r_sync_meta;
    end

    // Edges are only meaningful on sample cycles.
    assign w_rise   = tick & ~r_lvl &  r_sync;
    assign w_fall   = tick &  r_lvl & ~r_sync;
    assign w_at_max = (r_cnt == c_cnt_max);
    assign w_lvl    = tick ? r_sync : r_lvl;

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state        = r_state;
        w_cnt          = r_cnt;
        w_hi           = r_hi;
        w_high_count   = r_high_count;
        w_period_count = r_period_count;
        w_valid        = 1'b0;
        w_ovf_set      = 1'b0;

        if (tick) begin
            case (r_state)
                ST_ARM: begin
                    // Wait for a low sample so a partial first pulse is
                    // never measured.
                    if (!r_sync) begin
                        w_state = ST_WAIT_RISE;
                    end
                end

                ST_WAIT_RISE: begin
                    // First rise only starts the count; no report yet.
                    if (w_rise) begin
                        w_cnt   = c_cnt_one;
                        w_state = ST_HIGH;
                    end
                end

                ST_HIGH: begin
                    // A rise cannot be seen here, so saturation always
                    // means the phase is too long.
                    if (w_at_max) begin
                        w_ovf_set = 1'b1;
                        w_state   = ST_ARM;
                    end else if (w_fall) begin
                        w_hi    = r_cnt;
                        w_cnt   = r_cnt + c_cnt_one;
                        w_state = ST_LOW;
                    end else begin
                        w_cnt = r_cnt + c_cnt_one;
                    end
                end

                ST_LOW: begin
                    // A rise at saturation is still a legal, maximal period,
                    // so the rise check comes before the saturation check.
                    if (w_rise) begin
                        w_period_count = r_cnt;
                        w_high_count   = r_hi;
                        w_valid        = 1'b1;
                        w_cnt          = c_cnt_one;
                        w_state        = ST_HIGH;
                    end else if (w_at_max) begin
                        w_ovf_set = 1'b1;
                        w_state   = ST_ARM;
                    end else begin
                        w_cnt = r_cnt + c_cnt_one;
                    end
                end

                default: begin
                    w_state = ST_ARM;
                end
            endcase
        end

        // A new overflow event wins over a simultaneous clear.
        if (w_ovf_set) begin
            w_overflow = 1'b1;
        end else if (clr_ovf) begin
            w_overflow = 1'b0;
        end else begin
            w_overflow = r_overflow;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_ARM;
            r_lvl          <= 1'b0;
            r_cnt          <= '0;
            r_hi           <= '0;
            r_high_count   <= '0;
            r_period_count <= '0;
            r_valid        <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_lvl          <= w_lvl;
            r_cnt          <= w_cnt;
            r_hi           <= w_hi;
            r_high_count   <= w_high_count;
            r_period_count <= w_period_count;
            r_valid        <= w_valid;
            r_overflow     <= w_overflow;
        end
    end

    assign high_count   = r_high_count;
    assign period_count = r_period_count;
    assign valid        = r_valid;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_capture
//  Description : Directed self-checking bench for pwm_capture. Inputs are
//                driven 1 ns after each rising edge; outputs are sampled at
//                the same point, so a value driven after edge N is seen by
//                the FSM (through the 2-FF synchronizer) at edge N+3.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;

    localparam int CW = 10;

    logic          clk     = 1'b0;
    logic          reset   = 1'b1;
    logic          tick    = 1'b1;
    logic          pwm_in  = 1'b0;
    logic          clr_ovf = 1'b0;
    logic [CW-1:0] high_count;
    logic [CW-1:0] period_count;
    logic          valid;
    logic          overflow;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int tdiv   = 1;
    int dbl    = 0;
    logic prev_valid = 1'b0;

    int vc[$];
    int vh[$];
    int vp[$];

    int s2;
    int c0;
    int r0;
    int pre;

    pwm_capture #(.CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .pwm_in       (pwm_in),
        .clr_ovf      (clr_ovf),
        .high_count   (high_count),
        .period_count (period_count),
        .valid        (valid),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs after the edge, then drive the next inputs.
    task automatic step(input logic v, input logic c = 1'b0, input logic r = 1'b0);
        @(posedge clk);
        #1;
        cyc++;
        if (valid === 1'b1) begin
            if (prev_valid) dbl++;
            vc.push_back(cyc);
            vh.push_back(int'(high_count));
            vp.push_back(int'(period_count));
        end
        prev_valid = (valid === 1'b1);
        pwm_in  = v;
        clr_ovf = c;
        reset   = r;
        tick    = (tdiv == 1) ? 1'b1 : ((cyc % tdiv) == 0);
    endtask

    task automatic drive(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic do_reset(input logic v);
        step(v, 1'b0, 1'b1);
        step(v, 1'b0, 1'b1);
        vc.delete();
        vh.delete();
        vp.delete();
    endtask

    initial begin
        // ---------------- reset state ----------------
        do_reset(1'b0);
        step(1'b0);
        chk("rst_high_count",   high_count,   0);
        chk("rst_period_count", period_count, 0);
        chk("rst_valid",        valid,        0);
        chk("rst_overflow",     overflow,     0);

        // ---------------- 3 high / 7 low, tick every clk ----------------
        do_reset(1'b0);
        drive(1'b0, 5);
        s2 = 0;
        for (int p = 0; p < 7; p++) begin
            if (p == 1) s2 = cyc + 1;
            drive(1'b1, 3);
            drive(1'b0, 7);
        end
        drive(1'b0, 5);
        chk("t1_valid_count", vc.size(), 6);
        if (vc.size() > 0) chk("t1_first_valid_cycle", vc[0], s2 + 3);
        for (int i = 0; i < vc.size(); i++) begin
            chk("t1_high", vh[i], 3);
            chk("t1_period", vp[i], 10);
            if (i > 0) chk("t1_spacing", vc[i] - vc[i-1], 10);
        end

        // ---------------- 40 high / 60 low, tick every 4th clk ----------------
        tdiv = 4;
        do_reset(1'b0);
        drive(1'b0, 20);
        while ((cyc % 4) != 3) step(1'b0);
        for (int p = 0; p < 3; p++) begin
            drive(1'b1, 40);
            drive(1'b0, 60);
        end
        drive(1'b1, 40);
        drive(1'b0, 20);
        tdiv = 1;
        chk("t2_valid_count", vc.size(), 3);
        for (int i = 0; i < vc.size(); i++) begin
            chk("t2_high", vh[i], 10);
            chk("t2_period", vp[i], 25);
            if (i > 0) chk("t2_spacing", vc[i] - vc[i-1], 100);
        end

        // ---------------- partial first pulse rejected ----------------
        do_reset(1'b1);
        drive(1'b1, 5);
        drive(1'b0, 2);
        drive(1'b1, 2);
        drive(1'b0, 2);
        s2 = cyc + 1;
        drive(1'b1, 2);
        drive(1'b0, 2);
        drive(1'b1, 2);
        drive(1'b0, 2);
        drive(1'b0, 5);
        chk("t3_valid_count", vc.size(), 2);
        if (vc.size() > 0) begin
            chk("t3_first_cycle",  vc[0], s2 + 3);
            chk("t3_first_high",   vh[0], 2);
            chk("t3_first_period", vp[0], 4);
        end

        // ---------------- held high: saturation sets overflow ----------------
        do_reset(1'b0);
        drive(1'b0, 5);
        c0 = cyc + 1;
        drive(1'b1, 1025);
        step(1'b1);
        chk("t4_ovf_before_sat", overflow, 0);
        chk("t4_sat_cycle_ref", cyc, c0 + 1025);
        step(1'b1);
        chk("t4_ovf_at_sat", overflow, 1);
        drive(1'b1, 3);
        chk("t4_no_valid", vc.size(), 0);
        chk("t4_counts_hold", period_count, 0);

        // ---------------- clr_ovf without a concurrent event ----------------
        step(1'b1, 1'b1);
        chk("t5_ovf_before_clr", overflow, 1);
        step(1'b1);
        chk("t5_ovf_cleared", overflow, 0);

        // ---------------- 1023-sample period, then 1024 with clear ----------
        drive(1'b0, 5);
        r0 = cyc + 1;
        drive(1'b1, 1);
        drive(1'b0, 1022);
        drive(1'b1, 1);
        drive(1'b0, 1023);
        drive(1'b1, 1);
        step(1'b1, 1'b1);
        chk("t5_ovf_pre_sat", overflow, 0);
        step(1'b1);
        chk("t5_set_beats_clr", overflow, 1);
        chk("t4_max_valid_count", vc.size(), 1);
        if (vc.size() > 0) begin
            chk("t4_max_cycle",  vc[0], r0 + 1026);
            chk("t4_max_period", vp[0], 1023);
            chk("t4_max_high",   vh[0], 1);
        end
        drive(1'b1, 3);

        // ---------------- reset in the middle of LOW ----------------
        do_reset(1'b0);
        drive(1'b0, 5);
        for (int p = 0; p < 2; p++) begin
            drive(1'b1, 3);
            drive(1'b0, 7);
        end
        drive(1'b1, 3);
        drive(1'b0, 5);
        pre = vc.size();
        chk("t6_pre_valid_count", pre, 2);
        chk("t6_pre_high", high_count, 3);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0);
        chk("t6_rst_high_count",   high_count,   0);
        chk("t6_rst_period_count", period_count, 0);
        chk("t6_rst_valid",        valid,        0);
        chk("t6_rst_overflow",     overflow,     0);
        vc.delete();
        vh.delete();
        vp.delete();
        drive(1'b0, 1);
        drive(1'b1, 3);
        drive(1'b0, 7);
        s2 = cyc + 1;
        drive(1'b1, 3);
        drive(1'b0, 7);
        drive(1'b0, 5);
        chk("t6_post_valid_count", vc.size(), 1);
        if (vc.size() > 0) begin
            chk("t6_post_cycle",  vc[0], s2 + 3);
            chk("t6_post_high",   vh[0], 3);
            chk("t6_post_period", vp[0], 10);
        end

        chk("no_double_valid", dbl, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
